// File: rtl/vis_bytestream_if.sv
// Byte-wide AXI4-Stream link from the visibility serialiser
// toward the bus/readout logic.
interface vis_bytestream_if;
  logic       m_tvalid;
  logic       m_tready;
  logic       m_tlast;
  logic [7:0] m_tdata;

  modport master (
    output m_tvalid,
    output m_tlast,
    output m_tdata,
    input  m_tready
  );

  modport slave (
    input  m_tvalid,
    input  m_tlast,
    input  m_tdata,
    output m_tready
  );
endinterface

// File: rtl/vis_bytestream.sv
// Buffers accumulated visibilities in a FIFO and serialises each
// re/im pair LSB-first onto a byte-wide AXI4-Stream.
module vis_bytestream #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 16,
  parameter int ABITS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid_i,
  input  logic             last_i,
  input  logic [WIDTH-1:0] revis_i,
  input  logic [WIDTH-1:0] imvis_i,
  vis_bytestream_if.master m,
  output logic [ABITS:0]   level_o,
  output logic             overflow_o
);
  localparam int BYTES = (WIDTH + 7) / 8;
  localparam int EXT   = 8 * BYTES;
  localparam int SW    = 2 * EXT;
  localparam int EW    = 2 * WIDTH + 1;
  localparam int CBITS = $clog2(2 * BYTES);
  localparam logic [CBITS-1:0] LASTBEAT =
    CBITS'(2 * BYTES - 1);
  localparam logic [ABITS:0] FULL = (ABITS+1)'(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  logic [EW-1:0]    r_mem [DEPTH];
  logic [ABITS-1:0] r_wp;
  logic [ABITS-1:0] r_rp;
  logic [ABITS:0]   r_level;
  logic             r_ovf;

  state_t           r_state;
  logic [SW-1:0]    r_shift;
  logic [CBITS-1:0] r_cnt;
  logic             r_last;
  logic             r_tvalid;
  logic             r_tlast;

  logic             w_full;
  logic             w_empty;
  logic             w_wr;
  logic             w_hs;
  logic             w_endw;
  logic             w_pop;
  logic [EW-1:0]    w_head;
  logic             w_hlast;
  logic [EXT-1:0]   w_re_ext;
  logic [EXT-1:0]   w_im_ext;
  logic [SW-1:0]    w_load;

  assign w_full  = (r_level == FULL);
  assign w_empty = (r_level == '0);
  assign w_wr    = valid_i && !w_full;
  assign w_hs    = r_tvalid && m.m_tready;
  assign w_endw  = w_hs && (r_cnt == '0);
  // Pop either to start from idle or to chain words with no bubble.
  assign w_pop   = !w_empty && ((r_state == IDLE) || w_endw);

  assign w_head   = r_mem[r_rp];
  assign w_hlast  = w_head[EW-1];
  assign w_re_ext = EXT'($signed(w_head[WIDTH-1:0]));
  assign w_im_ext = EXT'($signed(w_head[2*WIDTH-1:WIDTH]));
  assign w_load   = {w_im_ext, w_re_ext};

  always_ff @(posedge clock) begin
    if (w_wr && !reset)
      r_mem[r_wp] <= {last_i, imvis_i, revis_i};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr)
        r_wp <= r_wp + 1'b1;
      if (w_pop)
        r_rp <= r_rp + 1'b1;
      r_level <= r_level
               + (ABITS+1)'(w_wr)
               - (ABITS+1)'(w_pop);
      r_ovf   <= r_ovf | (valid_i && w_full);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_last   <= 1'b0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_state  <= SEND;
            r_shift  <= w_load;
            r_cnt    <= LASTBEAT;
            r_last   <= w_hlast;
            r_tvalid <= 1'b1;
            r_tlast  <= 1'b0;
          end
        end
        SEND: begin
          if (w_hs) begin
            if (r_cnt != '0) begin
              r_shift <= {8'h00, r_shift[SW-1:8]};
              r_cnt   <= r_cnt - 1'b1;
              r_tlast <= (r_cnt == CBITS'(1)) && r_last;
            end else if (!w_empty) begin
              r_shift <= w_load;
              r_cnt   <= LASTBEAT;
              r_last  <= w_hlast;
              r_tlast <= 1'b0;
            end else begin
              r_state  <= IDLE;
              r_shift  <= '0;
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m.m_tvalid = r_tvalid;
  assign m.m_tlast  = r_tlast;
  assign m.m_tdata  = r_shift[7:0];
  assign level_o    = r_level;
  assign overflow_o = r_ovf;
endmodule

// File: tb/tb_vis_bytestream.sv
// Directed bench for vis_bytestream: byte order, latency,
// backpressure, overflow and reset behaviour.
module tb_vis_bytestream;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid_i = 1'b0;
  logic        last_i = 1'b0;
  logic [35:0] revis_i = '0;
  logic [35:0] imvis_i = '0;
  logic [4:0]  level_o;
  logic        overflow_o;

  vis_bytestream_if bus ();

  vis_bytestream #(.WIDTH(36), .DEPTH(16), .ABITS(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .valid_i    (valid_i),
    .last_i     (last_i),
    .revis_i    (revis_i),
    .imvis_i    (imvis_i),
    .m          (bus.master),
    .level_o    (level_o),
    .overflow_o (overflow_o)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_b[$];
  logic       exp_l[$];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // 10 bytes given in emission order, MSB of v first
  task automatic push80(input logic [79:0] v, input logic l);
    for (int i = 0; i < 10; i++) begin
      exp_b.push_back(v[79-8*i -: 8]);
      exp_l.push_back(l && (i == 9));
    end
  endtask

  function automatic logic lastflag(input int k);
    return (k == 8) || (k == 17);
  endfunction

  // word k: re = k, im = -k
  task automatic push_k(input int k);
    push80({8'(k), 32'h0, 8'(256 - k), 32'hFFFF_FFFF},
           lastflag(k));
  endtask

  task automatic drive(input logic [35:0] re,
                       input logic [35:0] im,
                       input logic l);
    valid_i = 1'b1;
    revis_i = re;
    imvis_i = im;
    last_i  = l;
    step();
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic fill(input int n);
    bus.m_tready = 1'b0;
    for (int k = 1; k <= n; k++) begin
      valid_i = 1'b1;
      revis_i = 36'(k);
      imvis_i = 36'(-k);
      last_i  = lastflag(k);
      step();
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  // mode 0: ready always; mode 1: ready toggles 1/0
  task automatic drain(input int mode, input int budget);
    int  idx = 0;
    int  cyc = 0;
    bit  started = 0;
    bit  rdy;
    while (idx < exp_b.size() && cyc < budget) begin
      rdy = (mode == 0) || (cyc % 2 == 0);
      bus.m_tready = rdy;
      if (started)
        check("tvalid_cont", 64'(bus.m_tvalid), 64'd1);
      if (bus.m_tvalid) begin
        started = 1;
        check($sformatf("tdata[%0d]", idx),
              64'(bus.m_tdata), 64'(exp_b[idx]));
        check($sformatf("tlast[%0d]", idx),
              64'(bus.m_tlast), 64'(exp_l[idx]));
        if (rdy) idx++;
      end
      step();
      cyc++;
    end
    check("drain_done", 64'(idx), 64'(exp_b.size()));
    bus.m_tready = 1'b1;
    exp_b.delete();
    exp_l.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_tvalid"}, 64'(bus.m_tvalid), 64'd0);
    check({tag, "_tlast"},  64'(bus.m_tlast),  64'd0);
    check({tag, "_tdata"},  64'(bus.m_tdata),  64'd0);
    check({tag, "_level"},  64'(level_o),      64'd0);
    check({tag, "_ovf"},    64'(overflow_o),   64'd0);
  endtask

  initial begin
    bus.m_tready = 1'b1;
    reset = 1'b1;
    step();
    step();
    check_reset_state("rst");
    reset = 1'b0;
    step();

    // single word, latency and byte order
    drive(36'h1_2345_6789, 36'hF_FFFF_FFFE, 1'b1);
    check("lat_n_tvalid", 64'(bus.m_tvalid), 64'd0);
    check("lat_n_level",  64'(level_o),      64'd1);
    step();
    check("lat_n1_tvalid", 64'(bus.m_tvalid), 64'd1);
    check("lat_n1_level",  64'(level_o),      64'd0);
    push80(80'h89_67_45_23_01_FE_FF_FF_FF_FF, 1'b1);
    drain(0, 40);
    check("t1_idle", 64'(bus.m_tvalid), 64'd0);

    // two back-to-back words
    valid_i = 1'b1;
    revis_i = 36'h0_0000_00AB;
    imvis_i = 36'h8_0000_0000;
    last_i  = 1'b0;
    step();
    revis_i = 36'h7_FFFF_FFFF;
    imvis_i = 36'h0_0000_0000;
    last_i  = 1'b1;
    step();
    valid_i = 1'b0;
    last_i  = 1'b0;
    push80(80'hAB_00_00_00_00_00_00_00_00_F8, 1'b0);
    push80(80'hFF_FF_FF_FF_07_00_00_00_00_00, 1'b1);
    drain(0, 60);
    check("t2_idle", 64'(bus.m_tvalid), 64'd0);

    // backpressure with alternating ready
    drive(36'h1_2345_6789, 36'hF_FFFF_FFFE, 1'b1);
    push80(80'h89_67_45_23_01_FE_FF_FF_FF_FF, 1'b1);
    drain(1, 60);
    check("t3_idle", 64'(bus.m_tvalid), 64'd0);

    // overflow: 17 accepted, word 18 dropped
    fill(17);
    check("ovf_lvl16", 64'(level_o),    64'd16);
    check("ovf_pre",   64'(overflow_o), 64'd0);
    drive(36'd18, 36'(-18), 1'b1);
    check("ovf_set",    64'(overflow_o), 64'd1);
    check("ovf_lvlkeep", 64'(level_o),   64'd16);
    step();
    step();
    check("ovf_sticky", 64'(overflow_o), 64'd1);
    for (int k = 1; k <= 17; k++) push_k(k);
    drain(0, 400);
    check("t4_idle",  64'(bus.m_tvalid), 64'd0);
    check("t4_level", 64'(level_o),      64'd0);
    check("t4_ovf",   64'(overflow_o),   64'd1);

    // write at full coinciding with final-byte pop
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_rst_ovf", 64'(overflow_o), 64'd0);
    fill(17);
    bus.m_tready = 1'b1;
    for (int i = 0; i < 9; i++) step();
    check("t5_byte10", 64'(bus.m_tdata), 64'hFF);
    check("t5_lvl",    64'(level_o),     64'd16);
    drive(36'd99, 36'd99, 1'b1);
    check("t5_ovf",   64'(overflow_o), 64'd1);
    check("t5_lvl15", 64'(level_o),    64'd15);
    for (int k = 2; k <= 17; k++) push_k(k);
    drain(0, 400);
    check("t5_idle", 64'(bus.m_tvalid), 64'd0);

    // reset mid-word with 3 words queued
    fill(4);
    check("t6_lvl3", 64'(level_o), 64'd3);
    bus.m_tready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("t6_byte5", 64'(bus.m_tdata), 64'h00);
    reset = 1'b1;
    step();
    check_reset_state("t6rst");
    reset = 1'b0;
    step();
    drive(36'h1_2345_6789, 36'hF_FFFF_FFFE, 1'b1);
    push80(80'h89_67_45_23_01_FE_FF_FF_FF_FF, 1'b1);
    drain(0, 40);
    check("t6_idle",  64'(bus.m_tvalid), 64'd0);
    check("t6_level", 64'(level_o),      64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
